// File: rtl/fetch_module_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// The optional same-cycle bypass path is enabled by defining FETCH_BYPASS_EN.
package fetch_module_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef logic [1:0] fetch_state_t;

  localparam int          FETCH_Q_DEPTH = 4;
  localparam logic [31:0] HLT_ENCODING  = 32'hD440_0000;

  typedef struct packed {
    logic [31:0] insnbits;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_module_if.sv
// Fetch-side bus bundle: instruction memory request/response and the
// fetch-to-dispatch valid/stall handshake.
interface fetch_module_if #(
  parameter int PC_WIDTH = 64
);

  logic                out_imem_req;
  logic [PC_WIDTH-1:0] out_imem_addr;
  logic [31:0]         in_imem_data;
  logic [31:0]         out_insnbits;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_fetch_done;
  logic                in_stall;

  modport master (
    output out_imem_req, out_imem_addr, out_insnbits, out_pc, out_fetch_done,
    input  in_imem_data, in_stall
  );

  modport slave (
    input  out_imem_req, out_imem_addr, out_insnbits, out_pc, out_fetch_done,
    output in_imem_data, in_stall
  );

endinterface

// File: rtl/fetch_module_queue.sv
// Circular FIFO holding fetched instruction words with their PCs.
// Depth must be a power of two so the pointers wrap by natural overflow.
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 64,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic [31:0]         push_insn,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic                pop,
  output logic [31:0]         head_insn,
  output logic [PC_WIDTH-1:0] head_pc,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  logic [31:0]         insn_mem_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      insn_mem_q[wr_ptr_q] <= push_insn;
      pc_mem_q[wr_ptr_q]   <= push_pc;
    end
  end

  assign head_insn = insn_mem_q[rd_ptr_q];
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/fetch_module.sv
// Instruction fetch front end: PC generation, single-outstanding imem reads,
// queueing and dispatch handshake. Optional FETCH_BYPASS_EN forwards data early.
module fetch_module
  import fetch_module_pkg::*;
#(
  parameter int                   FETCH_Q_DEPTH = fetch_module_pkg::FETCH_Q_DEPTH,
  parameter int                   PC_WIDTH      = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC      = '0,
  parameter logic [31:0]          HLT_ENCODING  = fetch_module_pkg::HLT_ENCODING,
  localparam int                  CNT_W         = $clog2(FETCH_Q_DEPTH) + 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic                in_redirect,
  input  logic [PC_WIDTH-1:0] in_redirect_pc,
  fetch_module_if.master      bus,
  output logic                out_halted,
  output logic [CNT_W-1:0]    out_q_count
);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic                redirect_eff, resp_valid, resp_hlt;
  logic                credit_ok, req, bypass_valid;
  logic                q_push, q_pop, q_empty;
  logic [31:0]         head_insn;
  logic [PC_WIDTH-1:0] head_pc;
  logic [CNT_W-1:0]    q_count;
  logic [CNT_W:0]      credit_sum;

  // A response arriving with HLT blocks the overlapping request, so nothing
  // past the halt is ever fetched.
  always_comb begin
    redirect_eff = in_redirect && (state_q != ST_IDLE);
    resp_valid   = inflight_q && !redirect_eff;
    resp_hlt     = resp_valid && (bus.in_imem_data == HLT_ENCODING);
    credit_sum   = {1'b0, q_count} + (CNT_W+1)'(inflight_q) + (CNT_W+1)'(1);
    credit_ok    = (credit_sum <= (CNT_W+1)'(FETCH_Q_DEPTH));
    req          = (state_q == ST_RUN) && !resp_hlt && credit_ok && !in_redirect;
`ifdef FETCH_BYPASS_EN
    bypass_valid = resp_valid && q_empty;
`else
    bypass_valid = 1'b0;
`endif
    q_pop        = !q_empty && !in_redirect && !bus.in_stall;
    q_push       = resp_valid && !(bypass_valid && !bus.in_stall);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    if (req) begin
      pc_d          = pc_q + PC_WIDTH'(4);
      inflight_pc_d = pc_q;
    end
    case (state_q)
      ST_IDLE: if (in_start) state_d = ST_RUN;
      ST_RUN:  if (resp_hlt) state_d = ST_HALTED;
      default: state_d = state_q;
    endcase
    if (redirect_eff) begin
      state_d    = ST_RUN;
      pc_d       = in_redirect_pc;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH    (FETCH_Q_DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_queue (
    .clk       (in_clk),
    .rst       (in_rst),
    .flush     (redirect_eff),
    .push      (q_push),
    .push_insn (bus.in_imem_data),
    .push_pc   (inflight_pc_q),
    .pop       (q_pop),
    .head_insn (head_insn),
    .head_pc   (head_pc),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Empty-queue outputs are forced to zero so stale storage never leaks out.
  assign bus.out_imem_req   = req;
  assign bus.out_imem_addr  = pc_q;
  assign bus.out_fetch_done = bypass_valid || (!q_empty && !in_redirect);
  assign bus.out_insnbits   = bypass_valid ? bus.in_imem_data :
                              (q_empty ? 32'h0 : head_insn);
  assign bus.out_pc         = bypass_valid ? inflight_pc_q :
                              (q_empty ? '0 : head_pc);
  assign out_halted         = (state_q == ST_HALTED);
  assign out_q_count        = q_count;

endmodule
